// File: rtl/accum_pkg.sv
// Shared accumulator-table definitions: default geometry, derived sizes and the
// sequencer state encoding used by both the read and write address controls.
package accum_pkg;

  localparam int unsigned MAX_OUT_ROWS = 128;
  localparam int unsigned MAX_OUT_COLS = 128;
  localparam int unsigned SYS_ARR_ROWS = 16;
  localparam int unsigned SYS_ARR_COLS = 16;
  localparam int unsigned DATA_WIDTH   = 32;

  localparam int unsigned NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS);
  localparam int unsigned NUM_SUBMATS_M  = MAX_OUT_ROWS / SYS_ARR_ROWS;
  localparam int unsigned NUM_SUBMATS_N  = MAX_OUT_COLS / SYS_ARR_COLS;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } accum_state_e;

  function automatic int unsigned clamp_dim(input int unsigned dim, input int unsigned max_dim);
    return (dim > max_dim) ? max_dim : dim;
  endfunction

endpackage

// File: rtl/accum_table_read_control_if.sv
// Table read port plus tagged output stream of the accumulator read sequencer.
// master = sequencer side, slave = table SRAM / downstream consumer side.
interface accum_table_read_control_if #(
  parameter int unsigned AddrW = $clog2(accum_pkg::NUM_ACCUM_ROWS),
  parameter int unsigned DataW = accum_pkg::SYS_ARR_COLS * accum_pkg::DATA_WIDTH,
  parameter int unsigned RowW  = $clog2(accum_pkg::MAX_OUT_ROWS),
  parameter int unsigned BlkW  = $clog2(accum_pkg::NUM_SUBMATS_N)
);

  logic             accum_rd_en;
  logic [AddrW-1:0] accum_rd_addr;
  logic [DataW-1:0] accum_rd_data;
  logic             out_valid;
  logic             out_ready;
  logic [DataW-1:0] out_data;
  logic [RowW-1:0]  out_row;
  logic [BlkW-1:0]  out_col_blk;
  logic             out_last;

  modport master (
    output accum_rd_en, accum_rd_addr, out_valid, out_data, out_row, out_col_blk, out_last,
    input  accum_rd_data, out_ready
  );

  modport slave (
    input  accum_rd_en, accum_rd_addr, out_valid, out_data, out_row, out_col_blk, out_last,
    output accum_rd_data, out_ready
  );

endinterface

// File: rtl/accum_rd_skid_fifo.sv
// Two-entry FIFO holding returned table rows with their tags; push and pop may
// coincide at any occupancy, including full.
module accum_rd_skid_fifo #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic [1:0]       o_count,
  output logic             o_valid
);

  logic [Width-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  // A full FIFO accepts a push only when the head leaves on the same edge.
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_valid = (r_count != 2'd0);

endmodule

// File: rtl/accum_table_read_control.sv
// Read-side sequencer for the accumulator table: walks column blocks (outer) and
// output rows (inner), reads each table row and streams it out with row/blk/last tags.
module accum_table_read_control #(
  parameter int unsigned MAX_OUT_ROWS = accum_pkg::MAX_OUT_ROWS,
  parameter int unsigned MAX_OUT_COLS = accum_pkg::MAX_OUT_COLS,
  parameter int unsigned SYS_ARR_ROWS = accum_pkg::SYS_ARR_ROWS,
  parameter int unsigned SYS_ARR_COLS = accum_pkg::SYS_ARR_COLS,
  parameter int unsigned DATA_WIDTH   = accum_pkg::DATA_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [$clog2(MAX_OUT_ROWS / SYS_ARR_ROWS):0] num_submats_m,
  input  logic [$clog2(MAX_OUT_COLS / SYS_ARR_COLS):0] num_submats_n,
  output logic busy,
  output logic done,
  accum_table_read_control_if.master bus
);

  import accum_pkg::*;

  localparam int unsigned NumSubmatsM  = MAX_OUT_ROWS / SYS_ARR_ROWS;
  localparam int unsigned NumSubmatsN  = MAX_OUT_COLS / SYS_ARR_COLS;
  localparam int unsigned NumAccumRows = MAX_OUT_ROWS * NumSubmatsN;
  localparam int unsigned AddrW        = $clog2(NumAccumRows);
  localparam int unsigned RowW         = $clog2(MAX_OUT_ROWS);
  localparam int unsigned BlkW         = $clog2(NumSubmatsN);
  localparam int unsigned MW           = $clog2(NumSubmatsM) + 1;
  localparam int unsigned NW           = $clog2(NumSubmatsN) + 1;
  localparam int unsigned LaneW        = SYS_ARR_COLS * DATA_WIDTH;
  localparam int unsigned FifoW        = LaneW + RowW + BlkW + 1;

  accum_state_e r_state;
  accum_state_e w_state_next;

  logic [RowW-1:0]  r_row_cnt;
  logic [BlkW-1:0]  r_blk_cnt;
  logic [RowW-1:0]  r_row_last;
  logic [BlkW-1:0]  r_blk_last;
  logic             r_inflight;
  logic [RowW-1:0]  r_tag_row;
  logic [BlkW-1:0]  r_tag_blk;
  logic             r_tag_last;

  logic [MW-1:0]    w_m;
  logic [NW-1:0]    w_n;
  logic             w_start_idle;
  logic             w_zero_dim;
  logic             w_row_wrap;
  logic             w_last_issue;
  logic [2:0]       w_occ;
  logic             w_issue;
  logic             w_pop;
  logic [AddrW-1:0] w_rd_addr;
  logic [FifoW-1:0] w_fifo_head;
  logic [1:0]       w_fifo_count;
  logic             w_fifo_valid;

  assign w_m = MW'(clamp_dim(32'(num_submats_m), NumSubmatsM));
  assign w_n = NW'(clamp_dim(32'(num_submats_n), NumSubmatsN));

  assign w_start_idle = (r_state == StIdle) && start;
  assign w_zero_dim   = (w_m == '0) || (w_n == '0);
  assign w_row_wrap   = (r_row_cnt == r_row_last);
  assign w_last_issue = w_row_wrap && (r_blk_cnt == r_blk_last);

  // Occupancy after this edge if we did not issue: FIFO entries plus the read in flight.
  assign w_pop   = w_fifo_valid && bus.out_ready;
  assign w_occ   = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue = (r_state == StRun) && (w_occ < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = w_zero_dim ? StDone : StRun;
      StRun:   if (w_issue && w_last_issue) w_state_next = StDrain;
      StDrain: if ((w_fifo_count == 2'd0) && !r_inflight) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy      = (r_state != StIdle);
    done      = (r_state == StDone);
    w_rd_addr = '0;
    if (w_issue) begin
      w_rd_addr = AddrW'(r_blk_cnt) * AddrW'(MAX_OUT_ROWS) + AddrW'(r_row_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_cnt  <= '0;
      r_blk_cnt  <= '0;
      r_row_last <= '0;
      r_blk_last <= '0;
    end else if (w_start_idle) begin
      r_row_cnt  <= '0;
      r_blk_cnt  <= '0;
      r_row_last <= RowW'(32'(w_m) * SYS_ARR_ROWS - 32'd1);
      r_blk_last <= BlkW'(32'(w_n) - 32'd1);
    end else if (w_issue) begin
      if (w_row_wrap) begin
        r_row_cnt <= '0;
        r_blk_cnt <= r_blk_cnt + 1'b1;
      end else begin
        r_row_cnt <= r_row_cnt + 1'b1;
      end
    end
  end

  // Tags ride one cycle behind the strobe so they meet the returning table data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_tag_row  <= '0;
      r_tag_blk  <= '0;
      r_tag_last <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag_row  <= r_row_cnt;
        r_tag_blk  <= r_blk_cnt;
        r_tag_last <= w_last_issue;
      end
    end
  end

  accum_rd_skid_fifo #(
    .Width (FifoW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  ({r_tag_last, r_tag_blk, r_tag_row, bus.accum_rd_data}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_valid (w_fifo_valid)
  );

  assign bus.accum_rd_en   = w_issue;
  assign bus.accum_rd_addr = w_rd_addr;
  assign bus.out_valid     = w_fifo_valid;
  assign bus.out_data      = w_fifo_head[LaneW-1:0];
  assign bus.out_row       = w_fifo_head[LaneW +: RowW];
  assign bus.out_col_blk   = w_fifo_head[LaneW + RowW +: BlkW];
  assign bus.out_last      = w_fifo_head[FifoW-1];

endmodule

// File: tb/tb_accum_table_read_control.sv
// Scoreboard bench for the accumulator read sequencer: runs push expected reads and
// beats into queues, a negedge monitor pops and compares what the DUT presents.
module tb_accum_table_read_control;
  import accum_pkg::*;

  localparam int unsigned LaneW = SYS_ARR_COLS * DATA_WIDTH;

  typedef struct {
    logic [LaneW-1:0] data;
    int               row;
    int               blk;
    bit               last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] num_m = 4'd0;
  logic [3:0] num_n = 4'd0;
  logic       busy;
  logic       done;

  accum_table_read_control_if bus_if ();

  accum_table_read_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_submats_m (num_m),
    .num_submats_n (num_n),
    .busy          (busy),
    .done          (done),
    .bus           (bus_if)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    run_start = 0;
  int    rdy_mode = 0;
  int    run_id = 0;
  beat_t exp_beats[$];
  int    exp_addrs[$];

  function automatic logic [LaneW-1:0] mem_word(input int addr);
    logic [LaneW-1:0] w;
    for (int k = 0; k < int'(SYS_ARR_COLS); k++) begin
      w[k*32 +: 32] = {6'd0, 10'(addr), 8'hA5, 8'(k)};
    end
    return w;
  endfunction

  task automatic chk(input string nm, input logic [LaneW-1:0] act, input logic [LaneW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Table SRAM model: one-cycle read latency, junk when not read.
  always @(posedge clk) begin
    bus_if.accum_rd_data <= bus_if.accum_rd_en ? mem_word(int'(bus_if.accum_rd_addr))
                                               : {LaneW{1'b1}};
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       bus_if.out_ready = cyc[0];
      2:       bus_if.out_ready = !(((cyc - run_start) >= 6) && ((cyc - run_start) < 26));
      default: bus_if.out_ready = 1'b1;
    endcase
  end

  // Monitor state
  int               seen_id = 0;
  int               outst = 0;
  int               first_en = -1;
  int               first_val = -1;
  int               cur_run = 0;
  int               max_run = 0;
  int               done_cnt = 0;
  bit               stall_prev = 0;
  logic [LaneW-1:0] sv_data;
  logic [6:0]       sv_row;
  logic [2:0]       sv_blk;
  logic             sv_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      outst      = 0;
      stall_prev = 0;
    end else begin
      if (run_id != seen_id) begin
        seen_id   = run_id;
        first_en  = -1;
        first_val = -1;
        cur_run   = 0;
        max_run   = 0;
        done_cnt  = 0;
      end
      if (bus_if.accum_rd_en) begin
        if (first_en < 0) first_en = cyc;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        if (exp_addrs.size() == 0) begin
          chk("unexpected_read", 1, 0);
        end else begin
          chk("rd_addr", bus_if.accum_rd_addr, exp_addrs.pop_front());
        end
      end else begin
        cur_run = 0;
      end
      if (bus_if.out_valid && first_val < 0) first_val = cyc;
      if (stall_prev) begin
        chk("stall_valid", bus_if.out_valid, 1);
        chk("stall_data", bus_if.out_data, sv_data);
        chk("stall_tags", {bus_if.out_last, bus_if.out_col_blk, bus_if.out_row},
            {sv_last, sv_blk, sv_row});
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (exp_beats.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          beat_t e;
          e = exp_beats.pop_front();
          chk("out_data", bus_if.out_data, e.data);
          chk("out_row", bus_if.out_row, e.row);
          chk("out_col_blk", bus_if.out_col_blk, e.blk);
          chk("out_last", bus_if.out_last, e.last);
        end
      end
      outst = outst + int'(bus_if.accum_rd_en) - int'(bus_if.out_valid && bus_if.out_ready);
      if (bus_if.accum_rd_en) chk("outstanding_le_2", (outst <= 2), 1);
      if (done) done_cnt++;
      stall_prev = bus_if.out_valid && !bus_if.out_ready;
      sv_data    = bus_if.out_data;
      sv_row     = bus_if.out_row;
      sv_blk     = bus_if.out_col_blk;
      sv_last    = bus_if.out_last;
    end
  end

  task automatic load_expect(input int em, input int en);
    for (int b = 0; b < en; b++) begin
      for (int r = 0; r < em * 16; r++) begin
        exp_addrs.push_back(b * 128 + r);
        exp_beats.push_back('{mem_word(b * 128 + r), r, b, (b == en - 1) && (r == em * 16 - 1)});
      end
    end
  endtask

  task automatic run(input int m, input int n, input int mode, input bit poke);
    int  em;
    int  en;
    bit  finished;
    em = (m > 8) ? 8 : m;
    en = (n > 8) ? 8 : n;
    finished = 0;
    rdy_mode = mode;
    load_expect(em, en);
    run_id++;
    @(negedge clk);
    run_start = cyc;
    num_m = 4'(m);
    num_n = 4'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (poke && i == 6) begin
        start = 1'b1;
        num_m = 4'd3;
        num_n = 4'd3;
      end else begin
        start = 1'b0;
      end
      if (!busy) begin
        finished = 1;
        break;
      end
    end
    chk("run_finished", finished, 1);
    @(negedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("reads_left", exp_addrs.size(), 0);
    chk("beats_left", exp_beats.size(), 0);
    if (em * en == 0) begin
      chk("no_reads", (first_en == -1) && (first_val == -1), 1);
    end else begin
      chk("first_valid_latency", first_val - first_en, 2);
      if (mode == 0) chk("back_to_back_reads", max_run, em * en * 16);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", bus_if.accum_rd_en, 0);
    chk("rst_rd_addr", bus_if.accum_rd_addr, 0);
    chk("rst_out_valid", bus_if.out_valid, 0);
    chk("rst_out_data", bus_if.out_data, 0);
    chk("rst_out_tags", {bus_if.out_last, bus_if.out_col_blk, bus_if.out_row}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(1, 1, 0, 0);
    run(2, 2, 0, 0);
    run(2, 1, 1, 0);
    run(2, 1, 2, 0);
    run(1, 1, 0, 1);
    run(0, 1, 0, 0);
    run(1, 0, 0, 0);
    run(15, 1, 0, 0);

    // Reset in the middle of a 2x2 readout, then a fresh 1x1 must start at addr 0.
    rdy_mode = 0;
    load_expect(2, 2);
    run_id++;
    @(negedge clk);
    num_m = 4'd2;
    num_n = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_en", bus_if.accum_rd_en, 0);
    chk("midrst_out_valid", bus_if.out_valid, 0);
    chk("midrst_out_data", bus_if.out_data, 0);
    exp_addrs.delete();
    exp_beats.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    run(1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
